// File: rtl/atm_auth_pkg.sv
// Shared types for the ATM account authenticator: request ops, response codes
// and the engine's FSM states.
package atm_auth_pkg;

   typedef enum logic [1:0] {
      OP_AUTH   = 2'd0,
      OP_CHPIN  = 2'd1,
      OP_UNLOCK = 2'd2,
      OP_RSVD   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_OK        = 3'd0,
      ST_NOT_FOUND = 3'd1,
      ST_BAD_PIN   = 3'd2,
      ST_LOCKED    = 3'd3,
      ST_SAME_PIN  = 3'd4,
      ST_BAD_OP    = 3'd5
   } status_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      CHECK = 2'd2,
      RESP  = 2'd3
   } auth_state_e;

   // Width of a failed-attempt counter that can hold 0..max_tries.
   function automatic int tries_width(input int max_tries);
      return $clog2(max_tries + 1);
   endfunction

endpackage

// File: rtl/auth_db.sv
// Account/PIN entry array: one load port, one combinational read port and one
// update port for PIN rewrite and failed-attempt/lock bookkeeping.
module auth_db #(
   parameter int NUM_ACCOUNTS = 10,
   parameter int ACC_W        = 11,
   parameter int PIN_W        = 16,
   parameter int TRY_W        = 2,
   parameter int IDX_W        = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [ACC_W-1:0] wr_acc_i,
   input  logic [PIN_W-1:0] wr_pin_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_valid_o,
   output logic [ACC_W-1:0] rd_acc_o,
   output logic [PIN_W-1:0] rd_pin_o,
   output logic [TRY_W-1:0] rd_tries_o,
   output logic             rd_locked_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_pin_we_i,
   input  logic [PIN_W-1:0] upd_pin_i,
   input  logic [TRY_W-1:0] upd_tries_i,
   input  logic             upd_locked_i
);

   logic [NUM_ACCOUNTS-1:0] valid_q;
   logic [NUM_ACCOUNTS-1:0] locked_q;
   logic [TRY_W-1:0]        tries_q [NUM_ACCOUNTS];
   logic [ACC_W-1:0]        acc_q   [NUM_ACCOUNTS];
   logic [PIN_W-1:0]        pin_q   [NUM_ACCOUNTS];
   logic                    wr_ok;

   assign wr_ok = wr_en_i && (32'(wr_idx_i) < NUM_ACCOUNTS);

   // Flags are reset; a load always wins over an update to the same entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= '0;
         locked_q <= '0;
         for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            tries_q[i] <= '0;
         end
      end else if (wr_ok) begin
         valid_q[wr_idx_i]  <= 1'b1;
         locked_q[wr_idx_i] <= 1'b0;
         tries_q[wr_idx_i]  <= '0;
      end else if (upd_en_i) begin
         locked_q[upd_idx_i] <= upd_locked_i;
         tries_q[upd_idx_i]  <= upd_tries_i;
      end
   end

   // Account numbers and PINs carry no reset; valid_q qualifies them.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         acc_q[wr_idx_i] <= wr_acc_i;
         pin_q[wr_idx_i] <= wr_pin_i;
      end else if (upd_en_i && upd_pin_we_i) begin
         pin_q[upd_idx_i] <= upd_pin_i;
      end
   end

   assign rd_valid_o  = valid_q[rd_idx_i];
   assign rd_acc_o    = acc_q[rd_idx_i];
   assign rd_pin_o    = pin_q[rd_idx_i];
   assign rd_tries_o  = tries_q[rd_idx_i];
   assign rd_locked_o = locked_q[rd_idx_i];

endmodule

// File: rtl/auth_engine.sv
// Sequential account authenticator: accepts one request at a time, scans the
// database one entry per cycle, applies the PIN/lockout rules, pulses a response.
module auth_engine
   import atm_auth_pkg::*;
#(
   parameter int NUM_ACCOUNTS = 10,
   parameter int ACC_W        = 11,
   parameter int PIN_W        = 16,
   parameter int MAX_TRIES    = 3,
   parameter int IDX_W        = $clog2(NUM_ACCOUNTS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [ACC_W-1:0] req_acc,
   input  logic [PIN_W-1:0] req_pin,
   input  logic [PIN_W-1:0] req_new_pin,
   output logic             rsp_valid,
   output logic [2:0]       rsp_status,
   output logic [IDX_W-1:0] rsp_index,
   input  logic             db_wr_en,
   input  logic [IDX_W-1:0] db_wr_idx,
   input  logic [ACC_W-1:0] db_wr_acc,
   input  logic [PIN_W-1:0] db_wr_pin
);

   localparam int               TRY_W     = tries_width(MAX_TRIES);
   localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ACCOUNTS - 1);

   auth_state_e      state_q;
   op_e              op_q;
   logic [ACC_W-1:0] acc_q;
   logic [PIN_W-1:0] pin_q;
   logic [PIN_W-1:0] new_pin_q;
   logic [IDX_W-1:0] idx_q;
   logic             req_ready_q;
   logic             rsp_valid_q;
   status_e          rsp_status_q;
   logic [IDX_W-1:0] rsp_index_q;

   logic             hs;
   logic             db_valid;
   logic [ACC_W-1:0] db_acc;
   logic [PIN_W-1:0] db_pin;
   logic [TRY_W-1:0] db_tries;
   logic             db_locked;
   logic             hit;
   logic [TRY_W-1:0] tries_inc;

   status_e          status_d;
   logic [TRY_W-1:0] tries_d;
   logic             locked_d;
   logic             pin_we_d;

   assign hs  = req_valid && req_ready_q;
   assign hit = db_valid && (db_acc == acc_q);

   auth_db #(
      .NUM_ACCOUNTS (NUM_ACCOUNTS),
      .ACC_W        (ACC_W),
      .PIN_W        (PIN_W),
      .TRY_W        (TRY_W),
      .IDX_W        (IDX_W)
   ) u_db (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (db_wr_en && req_ready_q),
      .wr_idx_i     (db_wr_idx),
      .wr_acc_i     (db_wr_acc),
      .wr_pin_i     (db_wr_pin),
      .rd_idx_i     (idx_q),
      .rd_valid_o   (db_valid),
      .rd_acc_o     (db_acc),
      .rd_pin_o     (db_pin),
      .rd_tries_o   (db_tries),
      .rd_locked_o  (db_locked),
      .upd_en_i     (state_q == CHECK),
      .upd_idx_i    (idx_q),
      .upd_pin_we_i (pin_we_d),
      .upd_pin_i    (new_pin_q),
      .upd_tries_i  (tries_d),
      .upd_locked_i (locked_d)
   );

   // Request fields are only meaningful after a handshake, so they carry no reset.
   always_ff @(posedge clk) begin
      if (hs) begin
         op_q      <= op_e'(req_op);
         acc_q     <= req_acc;
         pin_q     <= req_pin;
         new_pin_q <= req_new_pin;
      end
   end

   assign tries_inc = (db_tries >= TRIES_MAX) ? TRIES_MAX : db_tries + 1'b1;

   // Rule chain for the matched entry; first applicable rule decides.
   always_comb begin
      status_d = ST_OK;
      tries_d  = db_tries;
      locked_d = db_locked;
      pin_we_d = 1'b0;
      if (op_q == OP_UNLOCK) begin
         tries_d  = '0;
         locked_d = 1'b0;
      end else if (db_locked) begin
         status_d = ST_LOCKED;
      end else if (db_pin != pin_q) begin
         status_d = ST_BAD_PIN;
         tries_d  = tries_inc;
         locked_d = (tries_inc == TRIES_MAX);
      end else if ((op_q == OP_CHPIN) && (new_pin_q == db_pin)) begin
         status_d = ST_SAME_PIN;
         tries_d  = '0;
      end else begin
         tries_d  = '0;
         pin_we_d = (op_q == OP_CHPIN);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= ST_OK;
         rsp_index_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  idx_q       <= '0;
                  if (req_op == OP_RSVD) begin
                     state_q      <= RESP;
                     rsp_status_q <= ST_BAD_OP;
                     rsp_index_q  <= '0;
                  end else begin
                     state_q <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (hit) begin
                  state_q <= CHECK;
               end else if (idx_q == LAST_IDX) begin
                  state_q      <= RESP;
                  rsp_valid_q  <= 1'b1;
                  rsp_status_q <= ST_NOT_FOUND;
                  rsp_index_q  <= '0;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            CHECK: begin
               state_q      <= RESP;
               rsp_valid_q  <= 1'b1;
               rsp_status_q <= status_d;
               rsp_index_q  <= idx_q;
            end
            RESP: begin
               // Reserved ops enter RESP with the pulse still pending.
               if (rsp_valid_q) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  rsp_valid_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_status = rsp_status_q;
   assign rsp_index  = rsp_index_q;

endmodule

// File: doc/auth_engine.md
# auth_engine

Sequential, parametrised account authenticator for the ATM datapath. It holds a loadable account/PIN database and serves one request at a time over a valid/ready handshake: authenticate, change PIN, or admin-unlock. A multi-cycle FSM scans the database one entry per cycle. Per-account failed-attempt counters lock an account after `MAX_TRIES` consecutive bad PINs. It sits between the ATM control FSM and the transaction unit.

## Interface
- `NUM_ACCOUNTS`, default 10: database depth.
- `ACC_W`, default 11: account-number width.
- `PIN_W`, default 16: PIN width.
- `MAX_TRIES`, default 3: consecutive failures before lockout (≥1).
- `IDX_W`, default `$clog2(NUM_ACCOUNTS)`: index width (derived).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: engine idle, can accept.
- `req_op` in 2: `OP_AUTH`=0, `OP_CHPIN`=1, `OP_UNLOCK`=2; 3 is reserved and answers `ST_BAD_OP`.
- `req_acc` in `ACC_W`: account number.
- `req_pin` in `PIN_W`: current PIN.
- `req_new_pin` in `PIN_W`: new PIN, used by `OP_CHPIN` only.
- `rsp_valid` out 1: one-cycle response pulse, no backpressure.
- `rsp_status` out 3: status code (see Operation).
- `rsp_index` out `IDX_W`: matched entry index; 0 when not found.
- `db_wr_en` in 1: load entry.
- `db_wr_idx` in `IDX_W`: entry index to load.
- `db_wr_acc` in `ACC_W`: account number to load.
- `db_wr_pin` in `PIN_W`: PIN to load.

## Operation
- **Database**: per entry `valid`, `acc`, `pin`, `tries` (`$clog2(MAX_TRIES+1)` bits), `locked`.
  - Reset clears `valid`, `tries` and `locked`; `acc`/`pin` are don't-care.
  - A load writes `acc`/`pin`, sets `valid`, clears `tries` and `locked`.
  - Loads are honoured only when `req_ready`=1, and ignored otherwise.
  - A load and a handshake in the same cycle: the load applies first, and the request sees the new data.
  - `db_wr_idx` ≥ `NUM_ACCOUNTS` is ignored.
- **Status codes**: `ST_OK`=0, `ST_NOT_FOUND`=1, `ST_BAD_PIN`=2, `ST_LOCKED`=3, `ST_SAME_PIN`=4, `ST_BAD_OP`=5.
- **FSM states**: `IDLE` → `SCAN` → `CHECK` → `RESP` → `IDLE`.
  - `IDLE`: `req_ready`=1. Handshake (`req_valid`&`req_ready`) registers op/acc/pin/new_pin and clears the scan index. Input changes after the handshake are ignored.
  - `SCAN`: compares entry `scan_idx` (valid && acc match) per cycle. Match → `CHECK` and latch the index. No match at `NUM_ACCOUNTS-1` → `RESP` with `ST_NOT_FOUND`. Lowest matching index wins.
  - `CHECK`: evaluated in priority order; the first rule that applies sets the status.
    1. `OP_UNLOCK`: clear `locked`/`tries`; status `ST_OK`.
    2. `locked`: status `ST_LOCKED`; no PIN compare, counters unchanged.
    3. PIN mismatch: `tries`+1, saturating at `MAX_TRIES`; set `locked` when it reaches `MAX_TRIES`; status `ST_BAD_PIN`.
    4. `OP_AUTH`, PIN match: clear `tries`; status `ST_OK`.
    5. `OP_CHPIN`, PIN match, `req_new_pin` equal to stored PIN: clear `tries`; status `ST_SAME_PIN`; no write.
    6. `OP_CHPIN`, PIN match, different new PIN: write the new PIN, clear `tries`; status `ST_OK`.
  - `RESP`: `rsp_valid`=1 for exactly one cycle, with status and index, then `IDLE`.
- A reserved op is answered `ST_BAD_OP` straight from `IDLE`→`RESP`, with no scan.

## Timing
- All outputs are registered. Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_status`=0, `rsp_index`=0, FSM=`IDLE`.
- Counting the handshake edge as edge 0:
  - Match at index k: `rsp_valid` is high after edge k+2.
  - Not found: `rsp_valid` is high after edge `NUM_ACCOUNTS`.
  - Reserved op: `rsp_valid` is high after edge 1.
- `req_ready` drops after edge 0 and returns the cycle after `rsp_valid`.
- Back-to-back requests: the earliest next handshake is the cycle after `rsp_valid`.
- Database updates (PIN write, tries, lock) are visible from the edge that enters `RESP`.
- Reset asserted mid-operation aborts the request: no response, database flags cleared.

## Structure
- Package `atm_auth_pkg`: `op_e`, `status_e` enums and the FSM state enum `auth_state_e`.
- Sub-module `auth_db`: the entry array holding `valid`, `acc`, `pin`, `tries` and `locked`.
  - Ports: load port, one read port by index, one update port (pin write / tries / lock).
  - `auth_engine` holds the FSM, request registers and scan counter.

## Test plan
- Load idx3 = acc 0x2A / PIN 0x1234; `OP_AUTH` with 0x1234 → `ST_OK`, index 3, `rsp_valid` after edge 5.
- `OP_AUTH` acc 0x7FF (absent) → `ST_NOT_FOUND`, index 0, `rsp_valid` after edge 10.
- Three `OP_AUTH` to 0x2A with 0x0000 → `ST_BAD_PIN` ×3. Fourth with 0x1234 → `ST_LOCKED`. `OP_UNLOCK` → `ST_OK`. Then 0x1234 → `ST_OK`.
- `OP_CHPIN` 0x1234→0x1234 → `ST_SAME_PIN`. Then 0x1234→0x9999 → `ST_OK`. Then `OP_AUTH` 0x1234 → `ST_BAD_PIN`, and 0x9999 → `ST_OK`.
- Two bad PINs, then a good one, then a bad one → tries = 1 and not locked (success reset the counter).
- Drop `rst_n` during `SCAN` → no `rsp_valid`, `req_ready`=1, all entries invalid (next auth → `ST_NOT_FOUND`). Also: a `db_wr_en` pulse during `SCAN` is ignored.
